// File: rtl/inst_rom_ctrl.sv
// Instruction fetch front end: a one-word fetch buffer in front of a fixed-latency SRAM.
// A buffer miss stalls the pipeline for WAIT_CYCLES+1 cycles while the word is read.
module inst_rom_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              stallreq_o,
  input  logic              invalidate_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_oe_n_o,
  input  logic [31:0]       sram_data_i
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [29:0]       tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [29:0]       req_word;
  logic [ADDR_W-1:0] req_addr;
  logic              out_of_range;
  logic              hit;
  logic              miss;
  logic              unused_byte_sel;

  assign req_word        = rom_addr_i[31:2];
  assign req_addr        = rom_addr_i[ADDR_W+1:2];
  assign unused_byte_sel = ^rom_addr_i[1:0];

  // Any word-address bit above the SRAM width means the fetch targets nothing we back.
  generate
    if (ADDR_W < 30) begin : g_range
      assign out_of_range = |rom_addr_i[31:ADDR_W+2];
    end else begin : g_full
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign hit  = (state_q == S_IDLE) && valid_q && (tag_q == req_word);
  assign miss = (state_q == S_IDLE) && rom_ce_i && !out_of_range && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = req_addr;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          data_d  = sram_data_i;
          tag_d   = 30'(addr_q);
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A reload request beats a fill landing on the same edge.
    if (invalidate_i) valid_d = 1'b0;
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    rom_data_o  = '0;
    stallreq_o  = 1'b0;
    sram_oe_n_o = 1'b1;
    sram_addr_o = '0;
    if (rst) begin
      case (state_q)
        S_IDLE: begin
          if (rom_ce_i && !out_of_range) begin
            if (hit) begin
              rom_data_o = data_q;
            end else begin
              stallreq_o  = 1'b1;
              sram_oe_n_o = 1'b0;
              sram_addr_o = req_addr;
            end
          end
        end
        S_WAIT: begin
          stallreq_o  = rom_ce_i;
          sram_oe_n_o = 1'b0;
          sram_addr_o = addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: directed fetch scenarios plus a randomized fetch stream
// checked cycle by cycle against a transaction-level model of the fetch buffer.
module tb_inst_rom_ctrl;

  localparam int W  = 2;
  localparam int AW = 18;

  logic          clk;
  logic          rst;
  logic          rom_ce_i;
  logic [31:0]   rom_addr_i;
  logic [31:0]   rom_data_o;
  logic          stallreq_o;
  logic          invalidate_i;
  logic [AW-1:0] sram_addr_o;
  logic          sram_oe_n_o;
  logic [31:0]   sram_data_i;

  int checks = 0;
  int passed = 0;

  logic [51:0] obs;
  logic [51:0] want;
  assign obs = {rom_data_o, stallreq_o, sram_oe_n_o, sram_addr_o};

  localparam logic [51:0] QUIET = {32'h0, 1'b0, 1'b1, 18'h0};

  inst_rom_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .stallreq_o   (stallreq_o),
    .invalidate_i (invalidate_i),
    .sram_addr_o  (sram_addr_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_data_i  (sram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: word 4 is pinned, everything else is an address hash.
  function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
    if (a == 18'd4) return 32'h2401_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // SRAM model: data is only valid once the same address has been held with
  // output enable low for W prior edges; before that it returns garbage.
  int            run_q;
  logic          prev_low_q;
  logic [AW-1:0] prev_addr_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 0;
      prev_low_q  <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      prev_low_q  <= !sram_oe_n_o;
      prev_addr_q <= sram_addr_o;
      if (sram_oe_n_o) run_q <= 0;
      else if (prev_low_q && sram_addr_o == prev_addr_q) run_q <= run_q + 1;
      else run_q <= 1;
    end
  end
  always_comb begin
    sram_data_i = 32'hDEAD_BEEF;
    if (!sram_oe_n_o && prev_low_q && sram_addr_o == prev_addr_q && run_q >= W)
      sram_data_i = sram_word(sram_addr_o);
  end

  // Transaction-level reference: an outstanding read with a remaining-cycle count,
  // and a one-word buffer.
  bit            m_busy;
  bit            m_valid;
  int            m_left;
  logic [29:0]   m_tag;
  logic [31:0]   m_data;
  logic [AW-1:0] m_paddr;

  function automatic logic [51:0] model_out(input bit ce, input logic [31:0] a);
    if (m_busy) return {32'h0, ce, 1'b0, m_paddr};
    if (!ce || a[31:AW+2] != 0) return QUIET;
    if (m_valid && m_tag == a[31:2]) return {m_data, 1'b0, 1'b1, {AW{1'b0}}};
    return {32'h0, 1'b1, 1'b0, a[AW+1:2]};
  endfunction

  function automatic void model_step(input bit ce, input logic [31:0] a, input bit inv);
    if (m_busy) begin
      if (m_left == 1) begin
        m_busy  = 0;
        m_valid = 1;
        m_tag   = 30'(m_paddr);
        m_data  = sram_word(m_paddr);
        $display("random fill: word %h data %h", m_paddr, m_data);
      end else begin
        m_left = m_left - 1;
      end
    end else if (ce && a[31:AW+2] == 0 && !(m_valid && m_tag == a[31:2])) begin
      m_busy  = 1;
      m_left  = W;
      m_paddr = a[AW+1:2];
    end
    if (inv) m_valid = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    want = QUIET;
    checks++; if (obs !== want) $display("FAIL reset_async: got %h want %h", obs, want); else passed++;
    @(posedge clk); #1;
    checks++; if (obs !== want) $display("FAIL reset_held: got %h want %h", obs, want); else passed++;
    #2 rst = 1'b1;
    tick();
    checks++; if (obs !== want) $display("FAIL reset_after1: got %h want %h", obs, want); else passed++;
    tick();
    checks++; if (obs !== want) $display("FAIL reset_after2: got %h want %h", obs, want); else passed++;
    $display("reset: outputs quiet during and after reset");
  endtask

  task automatic test_basic_miss();
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0000_0010;
    for (int c = 0; c < W + 1; c++) begin
      #1;
      want = {32'h0, 1'b1, 1'b0, 18'd4};
      checks++; if (obs !== want) $display("FAIL miss_stall_c%0d: got %h want %h", c, obs, want); else passed++;
      tick();
    end
    #1;
    want = {32'h2401_0005, 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL miss_deliver: got %h want %h", obs, want); else passed++;
    $display("fetch 0x10: miss, %0d stall cycles, data %h", W + 1, rom_data_o);
  endtask

  task automatic test_hit();
    rom_addr_i = 32'h0000_0012;
    #1;
    want = {32'h2401_0005, 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL hit_same_word: got %h want %h", obs, want); else passed++;
    tick();
    checks++; if (obs !== want) $display("FAIL hit_repeat: got %h want %h", obs, want); else passed++;
    rom_ce_i = 1'b0;
    #1;
    want = QUIET;
    checks++; if (obs !== want) $display("FAIL hit_ce_low: got %h want %h", obs, want); else passed++;
    tick();
    $display("fetch 0x12: hit, data %h", 32'h2401_0005);
  endtask

  task automatic test_retarget();
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0000_0020;
    #1;
    want = {32'h0, 1'b1, 1'b0, 18'd8};
    checks++; if (obs !== want) $display("FAIL retarget_issue: got %h want %h", obs, want); else passed++;
    tick();
    rom_addr_i = 32'h0000_0040;
    #1;
    checks++; if (obs !== want) $display("FAIL retarget_wait1: got %h want %h", obs, want); else passed++;
    tick();
    rom_ce_i = 1'b0;
    #1;
    want = {32'h0, 1'b0, 1'b0, 18'd8};
    checks++; if (obs !== want) $display("FAIL retarget_wait2_ce_low: got %h want %h", obs, want); else passed++;
    tick();
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0000_0020;
    #1;
    want = {sram_word(18'd8), 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL retarget_word8_filled: got %h want %h", obs, want); else passed++;
    rom_addr_i = 32'h0000_0040;
    #1;
    want = {32'h0, 1'b1, 1'b0, 18'd16};
    checks++; if (obs !== want) $display("FAIL retarget_reissue16: got %h want %h", obs, want); else passed++;
    repeat (W + 1) tick();
    want = {sram_word(18'd16), 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL retarget_word16: got %h want %h", obs, want); else passed++;
    $display("fetch 0x20 retargeted to 0x40: word 8 filled, word 16 re-issued");
  endtask

  task automatic test_invalidate();
    rom_addr_i = 32'h0000_0010;
    #1;
    want = {32'h0, 1'b1, 1'b0, 18'd4};
    checks++; if (obs !== want) $display("FAIL inv_issue: got %h want %h", obs, want); else passed++;
    tick();
    tick();
    invalidate_i = 1'b1;
    #1;
    checks++; if (obs !== want) $display("FAIL inv_not_abort: got %h want %h", obs, want); else passed++;
    tick();
    invalidate_i = 1'b0;
    #1;
    checks++; if (obs !== want) $display("FAIL inv_fill_dropped: got %h want %h", obs, want); else passed++;
    repeat (W + 1) tick();
    want = {32'h2401_0005, 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL inv_refill: got %h want %h", obs, want); else passed++;
    invalidate_i = 1'b1;
    tick();
    invalidate_i = 1'b0;
    #1;
    want = {32'h0, 1'b1, 1'b0, 18'd4};
    checks++; if (obs !== want) $display("FAIL inv_idle_clears: got %h want %h", obs, want); else passed++;
    repeat (W + 1) tick();
    $display("fetch 0x10 with invalidate on fill edge: re-missed and refilled");
  endtask

  task automatic test_out_of_range();
    rom_addr_i = 32'h8000_0000;
    #1;
    want = QUIET;
    checks++; if (obs !== want) $display("FAIL oor_top: got %h want %h", obs, want); else passed++;
    tick();
    rom_addr_i = 32'h0010_0010;
    #1;
    checks++; if (obs !== want) $display("FAIL oor_alias: got %h want %h", obs, want); else passed++;
    tick();
    rom_addr_i = 32'h0000_0010;
    #1;
    want = {32'h2401_0005, 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL oor_buffer_kept: got %h want %h", obs, want); else passed++;
    rom_addr_i = 32'h000F_FFFF;
    #1;
    want = {32'h0, 1'b1, 1'b0, 18'h3FFFF};
    checks++; if (obs !== want) $display("FAIL oor_edge_in_range: got %h want %h", obs, want); else passed++;
    repeat (W + 1) tick();
    want = {sram_word(18'h3FFFF), 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL oor_edge_fill: got %h want %h", obs, want); else passed++;
    $display("out-of-range fetches ignored, top in-range word filled");
  endtask

  task automatic test_reset_mid_wait();
    rom_addr_i = 32'h0000_0030;
    repeat (W + 1) tick();
    want = {sram_word(18'd12), 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL rmw_prefill: got %h want %h", obs, want); else passed++;
    rom_addr_i = 32'h0000_0050;
    tick();
    tick();
    want = {32'h0, 1'b1, 1'b0, 18'd20};
    checks++; if (obs !== want) $display("FAIL rmw_wait2: got %h want %h", obs, want); else passed++;
    rst = 1'b0;
    #1;
    want = QUIET;
    checks++; if (obs !== want) $display("FAIL rmw_async: got %h want %h", obs, want); else passed++;
    @(posedge clk); #1;
    checks++; if (obs !== want) $display("FAIL rmw_held: got %h want %h", obs, want); else passed++;
    #2 rst = 1'b1;
    rom_addr_i = 32'h0000_0030;
    #1;
    want = {32'h0, 1'b1, 1'b0, 18'd12};
    checks++; if (obs !== want) $display("FAIL rmw_remiss: got %h want %h", obs, want); else passed++;
    repeat (W + 1) tick();
    want = {sram_word(18'd12), 1'b0, 1'b1, 18'd0};
    checks++; if (obs !== want) $display("FAIL rmw_refill: got %h want %h", obs, want); else passed++;
    $display("reset in second wait cycle: read abandoned, 0x30 re-missed");
  endtask

  task automatic test_random();
    bit          ce;
    bit          inv;
    logic [31:0] a;
    int          sel;
    rom_ce_i = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    m_busy  = 0;
    m_valid = 0;
    m_left  = 0;
    m_tag   = '0;
    m_data  = '0;
    m_paddr = '0;
    tick();
    for (int i = 0; i < 400; i++) begin
      ce  = ($urandom_range(0, 9) < 8);
      inv = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7) a = {$urandom_range(0, 7), 2'b00} | 32'($urandom_range(0, 3));
      else if (sel < 8) a = $urandom & 32'h000F_FFFF;
      else a = (32'h0010_0000 << $urandom_range(0, 11)) | ($urandom & 32'h0000_00FF);
      rom_ce_i     = ce;
      rom_addr_i   = a;
      invalidate_i = inv;
      #2;
      want = model_out(ce, a);
      checks++; if (obs !== want) $display("FAIL random_cycle%0d: got %h want %h", i, obs, want); else passed++;
      model_step(ce, a, inv);
      tick();
    end
    invalidate_i = 1'b0;
    rom_ce_i     = 1'b0;
  endtask

  initial begin
    rom_ce_i     = 1'b0;
    rom_addr_i   = '0;
    invalidate_i = 1'b0;
    rst          = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_basic_miss();
    test_hit();
    test_retarget();
    test_invalidate();
    test_out_of_range();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
